// File: rtl/cache_pkg.sv
// cache_pkg: shared state encoding and geometry helpers for the cache<->memory responder.
package cache_pkg;
   typedef enum logic [1:0] {IDLE, WAIT, XFER, RESP} mem_state_t;
   localparam int LINE_W     = 128;
   localparam int OFS        = 4;
   localparam int LINE_IDX_W = 8;
   function automatic int line_w(input int word_w, input int wpl);
      return word_w * wpl;
   endfunction
   function automatic int ofs(input int word_w, input int wpl);
      return $clog2(word_w / 8) + $clog2(wpl);
   endfunction
   function automatic int line_idx_w(input int depth);
      return $clog2(depth);
   endfunction
endpackage

// File: rtl/mem_word_array.sv
// mem_word_array: single-port word-wide backing store, synchronous write, combinational read, no reset.
module mem_word_array #(
   parameter int WORD_W = 32,
   parameter int DEPTH  = 1024,
   parameter int AW     = 10
) (
   input  logic              clk,
   input  logic              we,
   input  logic [AW-1:0]     addr,
   input  logic [WORD_W-1:0] wdata,
   output logic [WORD_W-1:0] rdata
);
   logic [WORD_W-1:0] mem [DEPTH];
   always_ff @(posedge clk)
      if (we) mem[addr] <= wdata;
   assign rdata = mem[addr];
endmodule

// File: rtl/cache_mem_responder.sv
// cache_mem_responder: memory-side responder moving whole cache lines one word per cycle after a fixed latency.
module cache_mem_responder
   import cache_pkg::*;
#(
   parameter int WORD_W         = 32,
   parameter int WORDS_PER_LINE = 4,
   parameter int DEPTH_LINES    = 256,
   parameter int LATENCY        = 4,
   parameter int ADDR_W         = 32
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic                                 mem_read,
   input  logic                                 mem_write,
   input  logic [ADDR_W-1:0]                    mem_addr,
   input  logic [WORD_W*WORDS_PER_LINE-1:0]     mem_wdata,
   output logic [WORD_W*WORDS_PER_LINE-1:0]     mem_rdata,
   output logic                                 ca_resp,
   output logic                                 busy,
   output logic                                 error
);
   localparam int LW = line_w(WORD_W, WORDS_PER_LINE);
   localparam int OF = ofs(WORD_W, WORDS_PER_LINE);
   localparam int IW = line_idx_w(DEPTH_LINES);
   localparam int AW = $clog2(DEPTH_LINES * WORDS_PER_LINE);
   localparam int BW = WORDS_PER_LINE > 1 ? $clog2(WORDS_PER_LINE) : 1;
   localparam int CW = LATENCY > 1 ? $clog2(LATENCY) : 1;
   mem_state_t        state, state_n;
   logic              op_wr_q;
   logic [IW-1:0]     line_q;
   logic [LW-1:0]     wdata_q, rdata_q, rdata_n;
   logic [CW-1:0]     lat_cnt;
   logic [BW-1:0]     beat;
   logic [AW-1:0]     word_addr;
   logic [WORD_W-1:0] rd_word;
   logic              req, last_beat, lat_done, addr_unused;
   assign req         = mem_read ^ mem_write;
   assign last_beat   = beat == BW'(WORDS_PER_LINE - 1);
   assign lat_done    = lat_cnt == CW'(LATENCY - 1);
   assign word_addr   = AW'(line_q) * AW'(WORDS_PER_LINE) + AW'(beat);
   assign ca_resp     = state == RESP;
   assign busy        = state != IDLE;
   assign addr_unused = ^mem_addr;
   mem_word_array #(.WORD_W(WORD_W), .DEPTH(DEPTH_LINES * WORDS_PER_LINE), .AW(AW)) u_array (
      .clk   (clk),
      .we    (state == XFER && op_wr_q),
      .addr  (word_addr),
      .wdata (wdata_q[beat*WORD_W +: WORD_W]),
      .rdata (rd_word)
   );
   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (req) state_n = LATENCY == 0 ? XFER : WAIT;
         WAIT:    if (lat_done) state_n = XFER;
         XFER:    if (last_beat) state_n = RESP;
         default: state_n = IDLE;
      endcase
   end
   // the final beat is merged on the fly so mem_rdata is complete in the RESP cycle
   always_comb begin
      rdata_n = rdata_q;
      rdata_n[beat*WORD_W +: WORD_W] = rd_word;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state     <= IDLE;
         op_wr_q   <= 1'b0;
         line_q    <= '0;
         wdata_q   <= '0;
         rdata_q   <= '0;
         mem_rdata <= '0;
         lat_cnt   <= '0;
         beat      <= '0;
         error     <= 1'b0;
      end else begin
         state <= state_n;
         error <= state == IDLE && mem_read && mem_write;
         if (state == IDLE && req) begin
            op_wr_q <= mem_write;
            line_q  <= mem_addr[OF +: IW];
            wdata_q <= mem_wdata;
            lat_cnt <= '0;
            beat    <= '0;
         end
         if (state == WAIT) lat_cnt <= lat_cnt + 1'b1;
         if (state == XFER) begin
            beat <= beat + 1'b1;
            if (!op_wr_q) rdata_q <= rdata_n;
            if (!op_wr_q && last_beat) mem_rdata <= rdata_n;
         end
      end
endmodule

// File: tb/tb_cache_mem_responder.sv
// tb_cache_mem_responder: directed checks of the line responder with LATENCY=4 and LATENCY=0 builds.
module tb_cache_mem_responder;
   logic         clk = 1'b0, rst_n = 1'b0, mem_read = 1'b0, mem_write = 1'b0;
   logic [31:0]  mem_addr = '0;
   logic [127:0] mem_wdata = '0;
   logic [127:0] rdata4, rdata0, rd_at;
   logic         resp4, resp0, busy4, busy0, err4, err0;
   int           n_cmp = 0, n_err = 0, first, n, bcnt, ecnt;
   bit           sel = 1'b0;
   localparam logic [127:0] L1    = 128'h00000004_00000003_00000002_00000001;
   localparam logic [127:0] L3    = 128'h33333333_22222222_11111111_00000000;
   localparam logic [127:0] OLD   = 128'h00000014_00000013_00000012_00000011;
   localparam logic [127:0] NEW   = 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA;
   localparam logic [127:0] PART  = 128'h00000014_00000013_BBBBBBBB_AAAAAAAA;
   localparam logic [127:0] L6    = 128'h00000008_00000007_00000006_00000005;
   cache_mem_responder #(.LATENCY(4)) dut (
      .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(rdata4), .ca_resp(resp4), .busy(busy4), .error(err4));
   cache_mem_responder #(.LATENCY(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(rdata0), .ca_resp(resp0), .busy(busy0), .error(err0));
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   // issue a request at the current negedge, then observe 20 cycles (k-th sample follows accept edge + k-1)
   task automatic txn(input logic rd, input logic wr, input logic [31:0] addr, input logic [127:0] wd,
                      input int extra_rd_at);
      mem_read = rd; mem_write = wr; mem_addr = addr; mem_wdata = wd;
      first = 0; n = 0; bcnt = 0; ecnt = 0; rd_at = '0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (sel ? resp0 : resp4) begin
            n++;
            if (first == 0) begin
               first = k;
               rd_at = sel ? rdata0 : rdata4;
            end
         end
         if (sel ? busy0 : busy4) bcnt++;
         if (sel ? err0 : err4) ecnt++;
         mem_read = (k == extra_rd_at); mem_write = 1'b0; mem_wdata = ~wd;
      end
   endtask
   initial begin
      repeat (2) @(negedge clk);
      check("rst_resp", {127'b0, resp4}, 0);
      check("rst_busy", {127'b0, busy4}, 0);
      check("rst_error", {127'b0, err4}, 0);
      check("rst_rdata", rdata4, 0);
      rst_n = 1'b1;
      @(negedge clk);
      txn(1'b0, 1'b1, 32'h100, L1, 0);
      check("wr_latency", first, 9);
      check("wr_resp_count", n, 1);
      check("wr_busy_cycles", bcnt, 9);
      txn(1'b1, 1'b0, 32'h100, '0, 0);
      check("rd_latency", first, 9);
      check("rd_data_at_resp", rd_at, L1);
      check("rd_data_held", rdata4, L1);
      txn(1'b0, 1'b1, 32'h300, L3, 0);
      check("wr3_resp_count", n, 1);
      check("rdata_held_over_write", rdata4, L1);
      txn(1'b1, 1'b1, 32'h100, '0, 0);
      check("both_no_resp", n, 0);
      check("both_busy", bcnt, 0);
      check("both_error_pulse", ecnt, 1);
      check("both_rdata_held", rdata4, L1);
      txn(1'b1, 1'b0, 32'h300, '0, 2);
      check("ignored_req_count", n, 1);
      check("ignored_req_latency", first, 9);
      check("ignored_req_data", rd_at, L3);
      txn(1'b0, 1'b1, 32'h200, OLD, 0);
      check("old_wr_count", n, 1);
      mem_write = 1'b1; mem_addr = 32'h200; mem_wdata = NEW;
      @(negedge clk);
      mem_write = 1'b0;
      repeat (6) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midxfer_rst_resp", {127'b0, resp4}, 0);
      check("midxfer_rst_busy", {127'b0, busy4}, 0);
      check("midxfer_rst_error", {127'b0, err4}, 0);
      check("midxfer_rst_rdata", rdata4, 0);
      repeat (3) @(negedge clk);
      check("rst_hold_resp", {127'b0, resp4}, 0);
      rst_n = 1'b1;
      @(negedge clk);
      txn(1'b1, 1'b0, 32'h200, '0, 0);
      check("partial_line", rd_at, PART);
      sel = 1'b1;
      txn(1'b0, 1'b1, 32'h1100, L6, 0);
      check("lat0_wr_latency", first, 5);
      check("lat0_wr_count", n, 1);
      check("lat0_busy_cycles", bcnt, 5);
      txn(1'b1, 1'b0, 32'h100, '0, 0);
      check("lat0_rd_latency", first, 5);
      check("lat0_wrapped_data", rd_at, L6);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
